img_loader: RTL and testbench

IMG_LOADER -- requirements
Module: img_loader

---
 rtl/img_loader.sv | 165 ++++++++++++++++
 tb/tb_img_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_loader.sv
// img_loader: pulls a palette followed by a full frame of colour indices from
// a byte stream and turns them into write strobes for a palette RAM and an
// image RAM.
//
// Ports:
//   vga_clk   in   sole clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   one-cycle pulse, begins a load (honoured in IDLE only)
//   s_data    in   [7:0] stream byte
//   s_valid   in   s_data valid
//   s_ready   out  loader accepts s_data this cycle
//   pal_we    out  palette RAM write strobe
//   pal_addr  out  [7:0]  palette entry index
//   pal_d     out  [23:0] palette entry {R,G,B}
//   img_we    out  image RAM write strobe
//   img_addr  out  [18:0] pixel address, row-major y*H_PIXELS+x
//   img_d     out  [7:0]  colour index
//   busy      out  load in progress
//   done      out  one-cycle pulse when the load completes
module img_loader #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int PAL_ENTRIES = 256
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        pal_we,
  output logic [7:0]  pal_addr,
  output logic [23:0] pal_d,
  output logic        img_we,
  output logic [18:0] img_addr,
  output logic [7:0]  img_d,
  output logic        busy,
  output logic        done
);

  localparam int         NPIX     = H_PIXELS * V_LINES;
  localparam logic [8:0] PAL_LAST = 9'(PAL_ENTRIES - 1);
  localparam logic [18:0] PIX_LAST = 19'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, PALETTE, PIXELS, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;          // which colour byte of the entry comes next
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic [8:0]  entry_q, entry_d;      // one bit wider so PAL_ENTRIES=256 fits
  logic [18:0] pix_q, pix_d;
  logic        pal_we_q, pal_we_d;
  logic [7:0]  pal_addr_q, pal_addr_d;
  logic [23:0] pal_d_q, pal_d_d;
  logic        img_we_q, img_we_d;
  logic [18:0] img_addr_q, img_addr_d;
  logic [7:0]  img_d_q, img_d_d;
  logic        accept;

  // Ready and busy come straight from the state register, so they are glitch-free.
  assign s_ready = (state_q == PALETTE) || (state_q == PIXELS);
  assign busy    = s_ready;
  assign done    = (state_q == DONE);
  assign accept  = s_ready && s_valid;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    r_d        = r_q;
    g_d        = g_q;
    entry_d    = entry_q;
    pix_d      = pix_q;
    pal_we_d   = 1'b0;
    pal_addr_d = pal_addr_q;
    pal_d_d    = pal_d_q;
    img_we_d   = 1'b0;
    img_addr_d = img_addr_q;
    img_d_d    = img_d_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PALETTE;
          sel_d   = 2'd0;
          entry_d = 9'd0;
          pix_d   = 19'd0;
        end
      end
      PALETTE: begin
        if (accept) begin
          case (sel_q)
            2'd0: begin
              r_d   = s_data;
              sel_d = 2'd1;
            end
            2'd1: begin
              g_d   = s_data;
              sel_d = 2'd2;
            end
            default: begin
              // B byte completes the entry: emit it on the next cycle.
              pal_we_d   = 1'b1;
              pal_addr_d = entry_q[7:0];
              pal_d_d    = {r_q, g_q, s_data};
              sel_d      = 2'd0;
              entry_d    = entry_q + 9'd1;
              if (entry_q == PAL_LAST) state_d = PIXELS;
            end
          endcase
        end
      end
      PIXELS: begin
        if (accept) begin
          img_we_d   = 1'b1;
          img_addr_d = pix_q;
          img_d_d    = s_data;
          pix_d      = pix_q + 19'd1;
          if (pix_q == PIX_LAST) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the strobe registers too, which drops any write that the
  // previous cycle had scheduled.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      r_q        <= 8'd0;
      g_q        <= 8'd0;
      entry_q    <= 9'd0;
      pix_q      <= 19'd0;
      pal_we_q   <= 1'b0;
      pal_addr_q <= 8'd0;
      pal_d_q    <= 24'd0;
      img_we_q   <= 1'b0;
      img_addr_q <= 19'd0;
      img_d_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      r_q        <= r_d;
      g_q        <= g_d;
      entry_q    <= entry_d;
      pix_q      <= pix_d;
      pal_we_q   <= pal_we_d;
      pal_addr_q <= pal_addr_d;
      pal_d_q    <= pal_d_d;
      img_we_q   <= img_we_d;
      img_addr_q <= img_addr_d;
      img_d_q    <= img_d_d;
    end
  end

  assign pal_we   = pal_we_q;
  assign pal_addr = pal_addr_q;
  assign pal_d    = pal_d_q;
  assign img_we   = img_we_q;
  assign img_addr = img_addr_q;
  assign img_d    = img_d_q;

endmodule

// File: tb/tb_img_loader.sv
// Testbench for img_loader: a byte-index model predicts every output each
// cycle; literal expectations pin palette/pixel contents and a small-frame
// instance exercises the tiny-parameter corner.
module tb_img_loader;

  localparam int P     = 256;
  localparam int H     = 16;
  localparam int V     = 16;
  localparam int NPIX  = H * V;
  localparam int TOTAL = 3 * P + NPIX;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, pal_we, img_we, busy, done;
  logic [7:0]  pal_addr, img_d;
  logic [23:0] pal_d;
  logic [18:0] img_addr;

  logic        start2, s_valid2;
  logic [7:0]  s_data2;
  logic        s_ready2, pal_we2, img_we2, busy2, done2;
  logic [7:0]  pal_addr2, img_d2;
  logic [23:0] pal_d2;
  logic [18:0] img_addr2;

  img_loader #(.H_PIXELS(H), .V_LINES(V), .PAL_ENTRIES(P)) u_dut (
    .vga_clk(clk), .reset(reset), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_d(pal_d), .img_we(img_we), .img_addr(img_addr), .img_d(img_d),
    .busy(busy), .done(done));

  img_loader #(.H_PIXELS(4), .V_LINES(2), .PAL_ENTRIES(2)) u_small (
    .vga_clk(clk), .reset(reset), .start(start2), .s_data(s_data2),
    .s_valid(s_valid2), .s_ready(s_ready2), .pal_we(pal_we2), .pal_addr(pal_addr2),
    .pal_d(pal_d2), .img_we(img_we2), .img_addr(img_addr2), .img_d(img_d2),
    .busy(busy2), .done(done2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position k within the load ----------
  bit          m_on = 1'b0;
  bit          loading = 1'b0;
  int          k = 0;
  logic [7:0]  rgb [3];
  logic        exp_pal_we = 1'b0, exp_img_we = 1'b0, exp_done = 1'b0;
  logic [7:0]  exp_pal_addr = 8'd0, exp_img_d = 8'd0;
  logic [23:0] exp_pal_d = 24'd0;
  logic [18:0] exp_img_addr = 19'd0;

  // captured RAM contents and statistics
  logic [23:0] pal_ram [P];
  logic [7:0]  img_ram [NPIX];
  int          pal_cnt = 0, img_cnt = 0, done_cnt = 0;
  int          first_pal_addr = -1, first_img_addr = -1;
  logic [7:0]  last_img_d = 8'd0;

  always @(negedge clk) begin
    bit was_done;
    if (m_on) begin
      chk("s_ready", s_ready, loading);
      chk("busy", busy, loading);
      chk("done", done, exp_done);
      chk("pal_we", pal_we, exp_pal_we);
      chk("img_we", img_we, exp_img_we);
      chk("pal_addr", pal_addr, exp_pal_addr);
      chk("pal_d", pal_d, exp_pal_d);
      chk("img_addr", img_addr, exp_img_addr);
      chk("img_d", img_d, exp_img_d);
    end
    if (pal_we === 1'b1) begin
      if (pal_cnt == 0) first_pal_addr = int'(pal_addr);
      pal_ram[pal_addr] = pal_d;
      pal_cnt++;
    end
    if (img_we === 1'b1) begin
      if (img_cnt == 0) first_img_addr = int'(img_addr);
      if (img_addr < NPIX) img_ram[img_addr] = img_d;
      last_img_d = img_d;
      img_cnt++;
    end
    if (done === 1'b1) done_cnt++;

    was_done   = exp_done;
    exp_pal_we = 1'b0;
    exp_img_we = 1'b0;
    exp_done   = 1'b0;
    if (reset) begin
      loading = 1'b0; k = 0;
      exp_pal_addr = 8'd0; exp_pal_d = 24'd0;
      exp_img_addr = 19'd0; exp_img_d = 8'd0;
      m_on = 1'b1;
    end else if (!loading) begin
      if (start && !was_done) begin loading = 1'b1; k = 0; end
    end else if (s_valid) begin
      if (k < 3 * P) begin
        rgb[k % 3] = s_data;
        if (k % 3 == 2) begin
          exp_pal_we = 1'b1; exp_pal_addr = 8'(k / 3);
          exp_pal_d  = {rgb[0], rgb[1], rgb[2]};
        end
      end else begin
        exp_img_we = 1'b1; exp_img_addr = 19'(k - 3 * P); exp_img_d = s_data;
        if (k == TOTAL - 1) begin loading = 1'b0; exp_done = 1'b1; end
      end
      k++;
    end
  end

  // ---------------- small instance monitor ---------------------------------
  int          cyc = 0;
  int          p2_cnt = 0, i2_cnt = 0, d2_cnt = 0, last_acc2 = -1, done2_cyc = -1;
  logic [18:0] last_addr2 = 19'd0;
  logic [23:0] last_pal2 = 24'd0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (s_valid2 && s_ready2) last_acc2 = cyc;
    if (pal_we2 === 1'b1) begin p2_cnt++; last_pal2 = pal_d2; end
    if (img_we2 === 1'b1) begin
      chk("small_img_addr_seq", img_addr2, 19'(i2_cnt));
      last_addr2 = img_addr2; i2_cnt++;
    end
    if (done2 === 1'b1) begin d2_cnt++; done2_cyc = cyc; end
  end

  // ---------------- stimulus ------------------------------------------------
  logic [7:0] stream [TOTAL];

  // mode 0: continuous, 1: toggle every cycle, 2: random valid
  task automatic run_load(input int mode, input int gap_at, input int start_at,
                          input int abort_at, input bit rand_data);
    int idx, n, budget;
    bit acc, gapped;
    for (int i = 0; i < TOTAL; i++) begin
      if (rand_data) stream[i] = 8'($urandom);
      else if (i < 3 * P) begin
        n = i / 3;
        stream[i] = (i % 3 == 0) ? 8'(n) : (i % 3 == 1) ? (8'(n) ^ 8'hFF) : 8'h5A;
      end else stream[i] = 8'(i - 3 * P);
    end
    s_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    idx = 0; n = 0; gapped = 1'b0; budget = 4 * TOTAL + 200;
    while (idx < TOTAL && n < budget) begin
      if (idx == abort_at) begin
        reset = 1'b1; s_valid = 1'b1;
        @(posedge clk); #1; reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_s_ready", s_ready, 1'b0);
        chk("abort_pal_we", pal_we, 1'b0);
        chk("abort_img_we", img_we, 1'b0);
        return;
      end
      if (idx == gap_at && !gapped) begin
        gapped = 1'b1; s_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
      end
      start   = (idx == start_at);
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : ($urandom_range(0, 2) != 0);
      s_data  = stream[idx];
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      n++;
    end
    s_valid = 1'b0; start = 1'b0;
    checks++;
    if (idx != TOTAL) begin
      errors++;
      $display("FAIL load_timeout: got %0d bytes required %0d", idx, TOTAL);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [23:0] pal_snap [P];
  logic [7:0]  img_snap [NPIX];

  task automatic clear_stats();
    pal_cnt = 0; img_cnt = 0; done_cnt = 0; first_pal_addr = -1; first_img_addr = -1;
    for (int i = 0; i < P; i++) pal_ram[i] = 24'd0;
    for (int i = 0; i < NPIX; i++) img_ram[i] = 8'd0;
  endtask

  initial begin
    int diffs, idx2, n2;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    start2 = 1'b0; s_valid2 = 1'b0; s_data2 = 8'd0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pal_we", pal_we, 1'b0);
    chk("rst_img_we", img_we, 1'b0);
    chk("rst_pal_addr", pal_addr, 8'd0);
    chk("rst_pal_d", pal_d, 24'd0);
    chk("rst_img_addr", img_addr, 19'd0);
    chk("rst_img_d", img_d, 8'd0);
    @(posedge clk); #1;

    // continuous pattern load
    clear_stats();
    run_load(0, -1, -1, -1, 1'b0);
    chk("l1_pal_cnt", pal_cnt, P);
    chk("l1_img_cnt", img_cnt, NPIX);
    chk("l1_done_cnt", done_cnt, 1);
    chk("l1_pal0", pal_ram[0], 24'h00FF5A);
    chk("l1_pal255", pal_ram[255], 24'hFF005A);
    chk("l1_pal17", pal_ram[17], 24'h11EE5A);
    chk("l1_img100", img_ram[100], 8'h64);
    chk("l1_last_img_d", last_img_d, 8'hFF);
    for (int i = 0; i < P; i++) pal_snap[i] = pal_ram[i];
    for (int i = 0; i < NPIX; i++) img_snap[i] = img_ram[i];

    // toggled valid, 20-cycle gap mid-entry, stray start during pixels
    clear_stats();
    run_load(1, 301, 3 * P + 40, -1, 1'b0);
    diffs = 0;
    for (int i = 0; i < P; i++) if (pal_ram[i] !== pal_snap[i]) diffs++;
    for (int i = 0; i < NPIX; i++) if (img_ram[i] !== img_snap[i]) diffs++;
    chk("l2_ram_diffs", diffs, 0);
    chk("l2_done_cnt", done_cnt, 1);

    // valid data offered while idle must be ignored
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom);
      @(negedge clk); chk("idle_s_ready", s_ready, 1'b0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("idle_writes", pal_cnt + img_cnt, 0);
    @(posedge clk); #1;

    // random load aborted by reset after 100 pixel bytes, then a fresh load
    run_load(2, -1, -1, 3 * P + 100, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    run_load(2, -1, -1, -1, 1'b1);
    chk("l4_first_pal_addr", first_pal_addr, 0);
    chk("l4_first_img_addr", first_img_addr, 0);
    chk("l4_img_cnt", img_cnt, NPIX);
    chk("l4_done_cnt", done_cnt, 1);

    // tiny frame: 2 palette entries, 4x2 pixels
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    idx2 = 0; n2 = 0;
    while (idx2 < 14 && n2 < 100) begin
      s_valid2 = 1'b1; s_data2 = 8'(idx2);
      @(negedge clk);
      if (s_ready2) idx2++;
      @(posedge clk); #1;
      n2++;
    end
    s_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("small_pal_cnt", p2_cnt, 2);
    chk("small_last_pal", last_pal2, 24'h030405);
    chk("small_img_cnt", i2_cnt, 8);
    chk("small_last_addr", last_addr2, 19'd7);
    chk("small_done_cnt", d2_cnt, 1);
    chk("small_done_lat", done2_cyc, last_acc2 + 1);
    chk("small_ready_after", s_ready2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
